// File: rtl/symbol_serializer.sv
// Line-side serializer: takes 80-bit words of eight 10-bit symbols and emits one
// symbol per enabled clock, filling gaps with K28.5 commas at the current disparity.
module symbol_serializer #(
  parameter logic [15:0] SAT_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [79:0] din_8b10,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [9:0]  dout_10b,
  output logic        dout_valid,
  output logic        dout_comma,
  output logic        rd_out,
  output logic        disp_viol,
  output logic [15:0] underrun_cnt
);

  localparam logic [9:0] COMMA_NEG = 10'b0011111010;
  localparam logic [9:0] COMMA_POS = 10'b1100000101;

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [79:0] hold, hold_n;
  logic        hold_valid, hold_valid_n;
  logic [79:0] shift, shift_n;
  logic        started, started_n;

  logic [9:0]  sym;
  logic        is_comma;
  logic [3:0]  ones;
  logic        rd_n;
  logic        viol;
  logic [15:0] cnt_n;

  // Ready depends only on registered state, never on din_valid.
  assign din_ready = ~hold_valid;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    shift_n      = shift;
    started_n    = started;
    sym          = rd_out ? COMMA_POS : COMMA_NEG;
    is_comma     = 1'b0;
    cnt_n        = underrun_cnt;

    if (din_valid && !hold_valid) begin
      hold_n       = din_8b10;
      hold_valid_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (hold_valid) begin
          sym          = hold[9:0];
          shift_n      = hold;
          idx_n        = 3'd1;
          hold_valid_n = 1'b0;
          started_n    = 1'b1;
          state_n      = SEND;
        end else begin
          is_comma = 1'b1;
          if (started && underrun_cnt != SAT_MAX) cnt_n = underrun_cnt + 16'd1;
        end
      end
      SEND: begin
        for (int k = 0; k < 8; k++) begin
          if (idx == 3'(k)) sym = shift[10*k +: 10];
        end
        if (idx != 3'd7) begin
          idx_n = idx + 3'd1;
        end else if (hold_valid) begin
          // Next word already waiting: chain it in with no comma gap.
          shift_n      = hold;
          idx_n        = 3'd0;
          hold_valid_n = 1'b0;
        end else begin
          idx_n   = 3'd0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Disparity bookkeeping applies to commas too; they just never flag a violation.
    ones = 4'($countones(sym));
    rd_n = rd_out;
    viol = 1'b0;
    case (ones)
      4'd5: rd_n = rd_out;
      4'd6: begin rd_n = 1'b1; viol = rd_out;  end
      4'd4: begin rd_n = 1'b0; viol = ~rd_out; end
      default: viol = 1'b1;
    endcase
    viol = viol & ~is_comma;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 3'd0;
      hold         <= '0;
      hold_valid   <= 1'b0;
      shift        <= '0;
      started      <= 1'b0;
      dout_10b     <= '0;
      dout_valid   <= 1'b0;
      dout_comma   <= 1'b0;
      rd_out       <= 1'b0;
      disp_viol    <= 1'b0;
      underrun_cnt <= '0;
    end else if (en) begin
      state        <= state_n;
      idx          <= idx_n;
      hold         <= hold_n;
      hold_valid   <= hold_valid_n;
      shift        <= shift_n;
      started      <= started_n;
      dout_10b     <= sym;
      dout_valid   <= 1'b1;
      dout_comma   <= is_comma;
      rd_out       <= rd_n;
      disp_viol    <= viol;
      underrun_cnt <= cnt_n;
    end else begin
      dout_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_symbol_serializer.sv
// Directed bench for symbol_serializer: per-edge vector table plus hand-written
// sequences for counter saturation and reset in the middle of a word.
module tb_symbol_serializer;

  logic        clk = 1'b0;
  logic        rst, en, din_valid;
  logic [79:0] din_8b10;
  logic        din_ready;
  logic [9:0]  dout_10b;
  logic        dout_valid, dout_comma, rd_out, disp_viol;
  logic [15:0] underrun_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  symbol_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .din_8b10     (din_8b10),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .dout_10b     (dout_10b),
    .dout_valid   (dout_valid),
    .dout_comma   (dout_comma),
    .rd_out       (rd_out),
    .disp_viol    (disp_viol),
    .underrun_cnt (underrun_cnt)
  );

  localparam logic [9:0] CN = 10'h0FA;  // K28.5, RD-
  localparam logic [9:0] CP = 10'h305;  // K28.5, RD+

  // Balanced symbols, symbol 0 in the low bits.
  localparam logic [79:0] W1 = {10'h057, 10'h04F, 10'h03E, 10'h03D,
                                10'h03B, 10'h037, 10'h02F, 10'h01F};
  localparam logic [79:0] W2 = {10'h31C, 10'h233, 10'h19C, 10'h2AA,
                                10'h155, 10'h1F0, 10'h3E0, 10'h0F8};
  // Two 6-ones symbols back to back at positions 2 and 3.
  localparam logic [79:0] W3 = {10'h01F, 10'h01F, 10'h01F, 10'h01F,
                                10'h0FC, 10'h0FC, 10'h307, 10'h0F8};

  typedef struct {
    logic        rst, en, dv;
    logic [79:0] din;
    logic [9:0]  dout;
    logic        valid, comma, rd, viol, ready;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic dv, input logic [79:0] d,
                     input logic [9:0] o, input logic v, input logic c, input logic rd,
                     input logic vi, input logic rdy, input logic [15:0] cnt);
    vec_t x;
    x.rst = r; x.en = e; x.dv = dv; x.din = d;
    x.dout = o; x.valid = v; x.comma = c; x.rd = rd; x.viol = vi; x.ready = rdy; x.cnt = cnt;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one edge, sample 1 ns later.
  task automatic step(input logic r, input logic e, input logic dv, input logic [79:0] d);
    rst = r; en = e; din_valid = dv; din_8b10 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [9:0] o, input logic v, input logic c,
                           input logic rd, input logic vi, input logic rdy, input logic [15:0] cnt);
    check({tag, " dout"},  32'(dout_10b),     32'(o));
    check({tag, " valid"}, 32'(dout_valid),   32'(v));
    check({tag, " comma"}, 32'(dout_comma),   32'(c));
    check({tag, " rd"},    32'(rd_out),       32'(rd));
    check({tag, " viol"},  32'(disp_viol),    32'(vi));
    check({tag, " ready"}, 32'(din_ready),    32'(rdy));
    check({tag, " cnt"},   32'(underrun_cnt), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; din_valid = 1'b0; din_8b10 = '0;

    //    rst en dv din    dout    v  c  rd vi rdy cnt
    add(1, 1, 0, '0,  10'h000, 0, 0, 0, 0, 1, 0);   // reset state
    // Idle after reset: alternating commas, counter not started.
    add(0, 1, 0, '0,  CN,      1, 1, 1, 0, 1, 0);
    add(0, 1, 0, '0,  CP,      1, 1, 0, 0, 1, 0);
    add(0, 1, 0, '0,  CN,      1, 1, 1, 0, 1, 0);
    add(0, 1, 0, '0,  CP,      1, 1, 0, 0, 1, 0);
    // Single word: accepted on the comma edge, symbols follow on the next eight edges.
    add(0, 1, 1, W1,  CN,      1, 1, 1, 0, 0, 0);
    add(0, 1, 0, '0,  10'h01F, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, '0,  10'h02F, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, '0,  10'h037, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, '0,  10'h03B, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, '0,  10'h03D, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, '0,  10'h03E, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, '0,  10'h04F, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, '0,  10'h057, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, '0,  CP,      1, 1, 0, 0, 1, 1);   // first underrun
    // Back-to-back W2 then W1 with din_valid held high: 16 data symbols, no comma.
    add(0, 1, 1, W2,  CN,      1, 1, 1, 0, 0, 2);
    add(0, 1, 1, W1,  10'h0F8, 1, 0, 1, 0, 1, 2);
    add(0, 1, 1, W1,  10'h3E0, 1, 0, 1, 0, 0, 2);
    add(0, 1, 1, W1,  10'h1F0, 1, 0, 1, 0, 0, 2);
    add(0, 1, 1, W1,  10'h155, 1, 0, 1, 0, 0, 2);
    add(0, 1, 1, W1,  10'h2AA, 1, 0, 1, 0, 0, 2);
    add(0, 1, 1, W1,  10'h19C, 1, 0, 1, 0, 0, 2);
    add(0, 1, 1, W1,  10'h233, 1, 0, 1, 0, 0, 2);
    add(0, 1, 1, W1,  10'h31C, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, '0,  10'h01F, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, '0,  10'h02F, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, '0,  10'h037, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, '0,  10'h03B, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, '0,  10'h03D, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, '0,  10'h03E, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, '0,  10'h04F, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, '0,  10'h057, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, '0,  CP,      1, 1, 0, 0, 1, 3);
    // Disparity violation: word starts at RD-, second 6-ones symbol flags once.
    add(0, 1, 0, '0,  CN,      1, 1, 1, 0, 1, 4);
    add(0, 1, 1, W3,  CP,      1, 1, 0, 0, 0, 5);
    add(0, 1, 0, '0,  10'h0F8, 1, 0, 0, 0, 1, 5);
    add(0, 1, 0, '0,  10'h307, 1, 0, 0, 0, 1, 5);
    add(0, 1, 0, '0,  10'h0FC, 1, 0, 1, 0, 1, 5);
    add(0, 1, 0, '0,  10'h0FC, 1, 0, 1, 1, 1, 5);
    add(0, 1, 0, '0,  10'h01F, 1, 0, 1, 0, 1, 5);
    add(0, 1, 0, '0,  10'h01F, 1, 0, 1, 0, 1, 5);
    add(0, 1, 0, '0,  10'h01F, 1, 0, 1, 0, 1, 5);
    add(0, 1, 0, '0,  10'h01F, 1, 0, 1, 0, 1, 5);
    add(0, 1, 0, '0,  CP,      1, 1, 0, 0, 1, 6);
    // Enable low for three edges mid-word: outputs freeze, sequence resumes.
    add(0, 1, 1, W1,  CN,      1, 1, 1, 0, 0, 7);
    add(0, 1, 0, '0,  10'h01F, 1, 0, 1, 0, 1, 7);
    add(0, 1, 0, '0,  10'h02F, 1, 0, 1, 0, 1, 7);
    add(0, 0, 0, '0,  10'h02F, 0, 0, 1, 0, 1, 7);
    add(0, 0, 0, '0,  10'h02F, 0, 0, 1, 0, 1, 7);
    add(0, 0, 0, '0,  10'h02F, 0, 0, 1, 0, 1, 7);
    add(0, 1, 0, '0,  10'h037, 1, 0, 1, 0, 1, 7);
    add(0, 1, 0, '0,  10'h03B, 1, 0, 1, 0, 1, 7);
    add(0, 1, 0, '0,  10'h03D, 1, 0, 1, 0, 1, 7);
    add(0, 1, 0, '0,  10'h03E, 1, 0, 1, 0, 1, 7);
    add(0, 1, 0, '0,  10'h04F, 1, 0, 1, 0, 1, 7);
    add(0, 1, 0, '0,  10'h057, 1, 0, 1, 0, 1, 7);
    add(0, 1, 0, '0,  CP,      1, 1, 0, 0, 1, 8);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].dv, vecs[i].din);
      check_all($sformatf("v%0d", i), vecs[i].dout, vecs[i].valid, vecs[i].comma,
                vecs[i].rd, vecs[i].viol, vecs[i].ready, vecs[i].cnt);
    end

    // Long idle stretch: counter is at 8 with RD-, so 65526 commas reach 16'hFFFE.
    for (int i = 0; i < 65526; i++) step(0, 1, 0, '0);
    check("sat_minus1 cnt", 32'(underrun_cnt), 32'hFFFE);
    check("sat_minus1 rd", 32'(rd_out), 32'd0);
    step(0, 1, 0, '0);
    check("sat_reach cnt", 32'(underrun_cnt), 32'hFFFF);
    for (int i = 0; i < 5000; i++) step(0, 1, 0, '0);
    check_all("sat_hold", CN, 1, 1, 1, 0, 1, 16'hFFFF);

    // Reset mid-word with a second word waiting in the hold register.
    step(0, 1, 1, W1);
    check_all("mw_acc", CP, 1, 1, 0, 0, 0, 16'hFFFF);
    step(0, 1, 0, '0);
    check_all("mw_s0", 10'h01F, 1, 0, 0, 0, 1, 16'hFFFF);
    step(0, 1, 1, W2);
    check_all("mw_s1", 10'h02F, 1, 0, 0, 0, 0, 16'hFFFF);
    step(1, 1, 0, '0);
    check_all("mw_rst", 10'h000, 0, 0, 0, 0, 1, 16'h0000);
    step(0, 1, 0, '0);
    check_all("post_rst0", CN, 1, 1, 1, 0, 1, 16'h0000);
    step(0, 1, 0, '0);
    check_all("post_rst1", CP, 1, 1, 0, 0, 1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
